// File: rtl/phv_packer_if.sv
// Upstream/downstream bus of the PHV packer: frame header, value stream
// from the sub-parser bank, and the assembled PHV handshake.
//   master : sub-parser side plus downstream ready (drives header/values/ready)
//   slave  : the packer (drives hdr_ready, phv_out_valid, phv_out)
interface phv_packer_if #(
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned VAL_IN_LEN = 48,
    parameter int unsigned META_LEN   = 256,
    parameter int unsigned CNT_LEN    = 6
);
    localparam int unsigned PHV_LEN = NUM_SLOTS * (16 + 32 + 48) + META_LEN;

    logic                  hdr_start;
    logic                  hdr_ready;
    logic [CNT_LEN-1:0]    hdr_num_vals;
    logic [META_LEN-1:0]   hdr_meta;
    logic                  val_in_valid;
    logic [VAL_IN_LEN-1:0] val_in;
    logic [1:0]            val_in_type;
    logic [5:0]            val_in_seq;
    logic                  phv_out_valid;
    logic [PHV_LEN-1:0]    phv_out;
    logic                  phv_out_ready;

    modport master (
        output hdr_start, hdr_num_vals, hdr_meta,
        output val_in_valid, val_in, val_in_type, val_in_seq,
        output phv_out_ready,
        input  hdr_ready, phv_out_valid, phv_out
    );

    modport slave (
        input  hdr_start, hdr_num_vals, hdr_meta,
        input  val_in_valid, val_in, val_in_type, val_in_seq,
        input  phv_out_ready,
        output hdr_ready, phv_out_valid, phv_out
    );
endinterface

// File: rtl/phv_packer.sv
// Packs the per-action value stream of the sub-parser bank into one PHV.
// A frame opens on an accepted hdr_start (count + metadata), collects that many
// typed values into 2B/4B/6B slots, then offers the PHV with valid/ready.
//   clk      : clock
//   areset   : synchronous reset, active-high
//   bus      : phv_packer_if.slave (header, value stream, PHV handshake)
//   drop_cnt : saturating count of values arriving outside COLLECT
module phv_packer #(
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned VAL_IN_LEN = 48,
    parameter int unsigned META_LEN   = 256,
    parameter int unsigned CNT_LEN    = 6
) (
    input  logic          clk,
    input  logic          areset,
    phv_packer_if.slave   bus,
    output logic [15:0]   drop_cnt
);
    localparam int unsigned SEL_W = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d, num_q, num_d;
    logic [META_LEN-1:0] meta_q, meta_d;
    logic [15:0]         slot2_q [NUM_SLOTS];
    logic [15:0]         slot2_d [NUM_SLOTS];
    logic [31:0]         slot4_q [NUM_SLOTS];
    logic [31:0]         slot4_d [NUM_SLOTS];
    logic [47:0]         slot6_q [NUM_SLOTS];
    logic [47:0]         slot6_d [NUM_SLOTS];
    logic [15:0]         drop_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;

    logic [VAL_IN_LEN-1:0] val_c;
    logic [SEL_W-1:0]      idx_c;
    logic [CNT_LEN-1:0]    cnt_inc_c;
    logic [15:0]           drop_inc_c;
    logic                  unused_seq_hi;

    assign val_c      = bus.val_in;
    // Slot index wraps: high sequence bits are ignored.
    assign idx_c      = bus.val_in_seq[SEL_W-1:0];
    assign unused_seq_hi = &{1'b0, bus.val_in_seq[5:SEL_W]};
    assign cnt_inc_c  = cnt_q + CNT_LEN'(1);
    assign drop_inc_c = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;

    // Next-state, slot writes and registered-output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        meta_d  = meta_q;
        slot2_d = slot2_q;
        slot4_d = slot4_q;
        slot6_d = slot6_q;
        drop_d  = drop_cnt;

        case (state_q)
            S_IDLE: begin
                // A value alongside the accepted header still counts as a drop.
                if (bus.val_in_valid) drop_d = drop_inc_c;
                if (bus.hdr_start) begin
                    meta_d  = bus.hdr_meta;
                    num_d   = bus.hdr_num_vals;
                    cnt_d   = '0;
                    slot2_d = '{default: '0};
                    slot4_d = '{default: '0};
                    slot6_d = '{default: '0};
                    state_d = (bus.hdr_num_vals == '0) ? S_OUT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.val_in_valid) begin
                    cnt_d = cnt_inc_c;
                    case (bus.val_in_type)
                        2'b01:   slot2_d[idx_c] = val_c[15:0];
                        2'b10:   slot4_d[idx_c] = val_c[31:0];
                        2'b11:   slot6_d[idx_c] = val_c[47:0];
                        default: ;
                    endcase
                    if (cnt_inc_c == num_q) state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.val_in_valid) drop_d = drop_inc_c;
                if (bus.phv_out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_OUT);
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            meta_q   <= '0;
            slot2_q  <= '{default: '0};
            slot4_q  <= '{default: '0};
            slot6_q  <= '{default: '0};
            drop_cnt <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            meta_q   <= meta_d;
            slot2_q  <= slot2_d;
            slot4_q  <= slot4_d;
            slot6_q  <= slot6_d;
            drop_cnt <= drop_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.phv_out_valid = valid_q;
    assign bus.hdr_ready     = ready_q;

    // PHV layout: {meta, 6B slots, 4B slots, 2B slots}, slot 0 lowest.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_pack
        assign bus.phv_out[16*i +: 16]                = slot2_q[i];
        assign bus.phv_out[16*NUM_SLOTS + 32*i +: 32] = slot4_q[i];
        assign bus.phv_out[48*NUM_SLOTS + 48*i +: 48] = slot6_q[i];
    end
    assign bus.phv_out[96*NUM_SLOTS +: META_LEN] = meta_q;

endmodule

// File: tb/tb_phv_packer.sv
// Bench for phv_packer: table of frames with hand-derived field expectations,
// a bit-level PHV model feeding a scoreboard queue, and hand sequences for
// backpressure-with-drops and mid-frame reset.
module tb_phv_packer;
    localparam int unsigned NS      = 8;
    localparam int unsigned VW      = 48;
    localparam int unsigned ML      = 256;
    localparam int unsigned CW      = 6;
    localparam int unsigned PHV_LEN = NS * 96 + ML;

    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] drop_cnt;

    phv_packer_if #(.NUM_SLOTS(NS), .VAL_IN_LEN(VW), .META_LEN(ML), .CNT_LEN(CW)) bus ();

    phv_packer #(.NUM_SLOTS(NS), .VAL_IN_LEN(VW), .META_LEN(ML), .CNT_LEN(CW)) dut (
        .clk      (clk),
        .areset   (areset),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]        num;
        logic [31:0]       meta;
        int                nv;
        logic [3:0][1:0]   typ;
        logic [3:0][5:0]   seq;
        logic [3:0][47:0]  val;
        bit                drop_with_start;
        int                f_off;
        int                f_w;
        logic [47:0]       f_exp;
    } frame_t;

    frame_t               tbl [7];
    logic [PHV_LEN-1:0]   sb_q [$];
    logic [PHV_LEN-1:0]   exp_phv;
    int                   n_chk  = 0;
    int                   n_pass = 0;
    int                   exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_phv(input string name, input logic [PHV_LEN-1:0] act,
                           input logic [PHV_LEN-1:0] exp);
        logic [PHV_LEN-1:0] a_s, e_s;
        int w;
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            for (w = 0; w < int'(PHV_LEN / 32); w++) begin
                a_s = act >> (32 * w);
                e_s = exp >> (32 * w);
                if (a_s[31:0] !== e_s[31:0]) break;
            end
            $display("FAIL %s: phv word %0d got %08h expected %08h", name, w, a_s[31:0], e_s[31:0]);
        end
    endtask

    // Model: overwrite a w-bit field at bit offset off.
    task automatic put(input int off, input int w, input logic [47:0] v);
        logic [PHV_LEN-1:0] mk;
        mk = PHV_LEN'((48'h1 << w) - 48'h1);
        exp_phv = (exp_phv & ~(mk << off)) | ((PHV_LEN'(v) & mk) << off);
    endtask

    task automatic model_write(input logic [1:0] t, input logic [5:0] sq, input logic [47:0] v);
        int s;
        s = int'(sq) % int'(NS);
        case (t)
            2'b01: put(16 * s, 16, v);
            2'b10: put(16 * int'(NS) + 32 * s, 32, v);
            2'b11: put(48 * int'(NS) + 48 * s, 48, v);
            default: ;
        endcase
    endtask

    task automatic send_val(input logic [1:0] t, input logic [5:0] sq, input logic [47:0] v);
        bus.val_in_valid = 1'b1;
        bus.val_in_type  = t;
        bus.val_in_seq   = sq;
        bus.val_in       = v;
        @(posedge clk); #1;
        bus.val_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.hdr_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, 64'(bus.hdr_ready), 64'd1);
    endtask

    task automatic start_frame(input logic [5:0] num, input logic [31:0] meta, input bit with_val);
        bus.hdr_start    = 1'b1;
        bus.hdr_num_vals = num;
        bus.hdr_meta     = ML'(meta);
        if (with_val) begin
            bus.val_in_valid = 1'b1;
            bus.val_in_type  = 2'b01;
            bus.val_in_seq   = 6'd0;
            bus.val_in       = 48'hBEEF;
            exp_drop++;
        end
        @(posedge clk); #1;
        bus.hdr_start    = 1'b0;
        bus.val_in_valid = 1'b0;
    endtask

    task automatic run_frame(input frame_t f, input int id);
        logic [PHV_LEN-1:0] sh;
        logic [47:0]        mk;
        exp_phv = '0;
        put(96 * int'(NS), 32, 48'(f.meta));
        for (int i = 0; i < f.nv; i++) model_write(f.typ[i], f.seq[i], f.val[i]);
        sb_q.push_back(exp_phv);
        start_frame(f.num, f.meta, f.drop_with_start);
        for (int i = 0; i < f.nv; i++) send_val(f.typ[i], f.seq[i], f.val[i]);
        chk($sformatf("valid_lat[%0d]", id), 64'(bus.phv_out_valid), 64'd1);
        sh = bus.phv_out >> f.f_off;
        mk = (48'h1 << f.f_w) - 48'h1;
        chk($sformatf("field[%0d]", id), 64'(sh[47:0] & mk), 64'(f.f_exp));
        chk($sformatf("drop[%0d]", id), 64'(drop_cnt), 64'(exp_drop));
        wait_idle($sformatf("idle[%0d]", id));
    endtask

    // Scoreboard: every PHV handshake pops one model entry.
    always @(negedge clk) begin
        if (!areset && bus.phv_out_valid && bus.phv_out_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
            else chk_phv("sb_phv", bus.phv_out, sb_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [PHV_LEN-1:0] hold_exp;

        tbl[0] = '{num: 6'd3, meta: 32'h0, nv: 3,
                   typ: {2'b00, 2'b11, 2'b10, 2'b01},
                   seq: {6'd0, 6'd7, 6'd2, 6'd0},
                   val: {48'h0, 48'hA1A2A3A4A5A6, 48'h11223344, 48'hABCD},
                   drop_with_start: 1'b0, f_off: 720, f_w: 48, f_exp: 48'hA1A2A3A4A5A6};
        tbl[1] = '{num: 6'd0, meta: 32'h5A, nv: 0, typ: '0, seq: '0, val: '0,
                   drop_with_start: 1'b0, f_off: 768, f_w: 8, f_exp: 48'h5A};
        tbl[2] = '{num: 6'd2, meta: 32'h1, nv: 2,
                   typ: {2'b00, 2'b00, 2'b01, 2'b01},
                   seq: {6'd0, 6'd0, 6'd1, 6'd1},
                   val: {48'h0, 48'h0, 48'h2222, 48'h1111},
                   drop_with_start: 1'b0, f_off: 16, f_w: 16, f_exp: 48'h2222};
        tbl[3] = '{num: 6'd1, meta: 32'h77, nv: 1,
                   typ: {2'b00, 2'b00, 2'b00, 2'b00},
                   seq: {6'd0, 6'd0, 6'd0, 6'd3},
                   val: {48'h0, 48'h0, 48'h0, 48'hFFFF},
                   drop_with_start: 1'b0, f_off: 48, f_w: 16, f_exp: 48'h0};
        tbl[4] = '{num: 6'd1, meta: 32'h2, nv: 1,
                   typ: {2'b00, 2'b00, 2'b00, 2'b10},
                   seq: {6'd0, 6'd0, 6'd0, 6'd9},
                   val: {48'h0, 48'h0, 48'h0, 48'hDEADBEEF},
                   drop_with_start: 1'b1, f_off: 160, f_w: 32, f_exp: 48'hDEADBEEF};
        tbl[5] = '{num: 6'd4, meta: 32'hC3, nv: 4,
                   typ: {2'b11, 2'b10, 2'b01, 2'b11},
                   seq: {6'd0, 6'd4, 6'd63, 6'd8},
                   val: {48'h665544332211, 48'h0BADF00D, 48'h9ABC, 48'h010203040506},
                   drop_with_start: 1'b0, f_off: 384, f_w: 48, f_exp: 48'h665544332211};
        tbl[6] = '{num: 6'd1, meta: 32'h42, nv: 1,
                   typ: {2'b00, 2'b00, 2'b00, 2'b10},
                   seq: {6'd0, 6'd0, 6'd0, 6'd3},
                   val: {48'h0, 48'h0, 48'h0, 48'hCAFEF00D},
                   drop_with_start: 1'b0, f_off: 224, f_w: 32, f_exp: 48'hCAFEF00D};

        areset            = 1'b1;
        bus.hdr_start     = 1'b0;
        bus.hdr_num_vals  = '0;
        bus.hdr_meta      = '0;
        bus.val_in_valid  = 1'b0;
        bus.val_in        = '0;
        bus.val_in_type   = 2'b00;
        bus.val_in_seq    = '0;
        bus.phv_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;

        chk("rst_valid", 64'(bus.phv_out_valid), 64'd0);
        chk_phv("rst_phv", bus.phv_out, '0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_hdr_ready", 64'(bus.hdr_ready), 64'd1);

        for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

        // Backpressure: PHV held for 10 cycles, two values dropped meanwhile.
        exp_phv = '0;
        put(96 * int'(NS), 32, 48'h33);
        model_write(2'b01, 6'd5, 48'h5555);
        hold_exp = exp_phv;
        sb_q.push_back(exp_phv);
        bus.phv_out_ready = 1'b0;
        start_frame(6'd1, 32'h33, 1'b0);
        send_val(2'b01, 6'd5, 48'h5555);
        for (int c = 0; c < 10; c++) begin
            if (c == 2 || c == 6) begin
                bus.val_in_valid = 1'b1;
                bus.val_in_type  = 2'b11;
                bus.val_in_seq   = 6'd7;
                bus.val_in       = 48'hFFFFFFFFFFFF;
                exp_drop++;
            end
            @(posedge clk); #1;
            bus.val_in_valid = 1'b0;
            chk_phv("hold_phv", bus.phv_out, hold_exp);
            chk("hold_valid", 64'(bus.phv_out_valid), 64'd1);
        end
        chk("hold_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("hold_hdr_ready", 64'(bus.hdr_ready), 64'd0);
        bus.phv_out_ready = 1'b1;
        wait_idle("hold_release");
        chk("post_valid", 64'(bus.phv_out_valid), 64'd0);

        // Reset mid-COLLECT after one of four values.
        start_frame(6'd4, 32'h99, 1'b0);
        send_val(2'b01, 6'd2, 48'h7777);
        areset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(bus.phv_out_valid), 64'd0);
        chk_phv("mid_rst_phv", bus.phv_out, '0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        chk("mid_rst_hdr_ready", 64'(bus.hdr_ready), 64'd1);
        areset = 1'b0;
        exp_drop = 0;
        run_frame(tbl[6], 6);

        repeat (3) @(posedge clk);
        #1 chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
